// File: rtl/cic_dsm_decimator.sv
// Hogenauer CIC decimator turning a 1-bit DSM stream (1 -> +1, 0 -> -1) back into
// signed PCM: pipelined integrators at the bit rate, decimate by 2^DECIM_LOG2, registered combs, scale/saturate.
module cic_dsm_decimator #(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic                        dsm_in,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid
);

  localparam int ACC_W = ORDER * DECIM_LOG2 + 2;
  localparam int S     = ORDER * DECIM_LOG2 + 1 - OUT_WIDTH;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_POS_ONE = acc_t'(1);
  localparam acc_t ACC_NEG_ONE = '1;
  localparam acc_t POS_FS      = acc_t'(1) <<< (OUT_WIDTH - 1);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("cic_dsm_decimator: ORDER must be in 1..4");
  end
  if (DECIM_LOG2 < 1 || DECIM_LOG2 > 10) begin : g_bad_decim
    $error("cic_dsm_decimator: DECIM_LOG2 must be in 1..10");
  end
  if (ORDER * DECIM_LOG2 + 1 < OUT_WIDTH) begin : g_bad_width
    $error("cic_dsm_decimator: OUT_WIDTH exceeds the CIC bit growth");
  end

  acc_t                  integ_q [ORDER];
  acc_t                  integ_d [ORDER];
  acc_t                  comb_x  [ORDER+1];
  logic                  comb_v  [ORDER+1];
  logic [DECIM_LOG2-1:0] cnt_reg;
  logic                  decim_event;
  acc_t                  step;
  acc_t                  cin_reg;
  logic                  cin_v_reg;
  acc_t                  shifted;
  logic signed [OUT_WIDTH-1:0] out_next;

  assign step        = dsm_in ? ACC_POS_ONE : ACC_NEG_ONE;
  assign decim_event = in_en && (cnt_reg == '1);

  // Each integrator adds the previous stage's registered value, so the chain is pipelined.
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_integ
    acc_t integ_reg;
    acc_t addend;
    if (gi == 0) begin : g_first
      assign addend = step;
    end else begin : g_rest
      assign addend = integ_q[gi-1];
    end
    assign integ_d[gi] = integ_reg + addend;
    assign integ_q[gi] = integ_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        integ_reg <= '0;
      end else if (in_en) begin
        integ_reg <= integ_d[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (in_en) begin
      cnt_reg <= cnt_reg + DECIM_LOG2'(1);
    end
  end

  // Capture the post-update last integrator so the block sum includes the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cin_reg   <= '0;
      cin_v_reg <= 1'b0;
    end else begin
      cin_v_reg <= decim_event;
      if (decim_event) begin
        cin_reg <= integ_d[ORDER-1];
      end
    end
  end

  assign comb_x[0] = cin_reg;
  assign comb_v[0] = cin_v_reg;

  for (genvar gi = 0; gi < ORDER; gi++) begin : g_comb
    acc_t y_reg;
    acc_t dly_reg;
    logic v_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_reg   <= '0;
        dly_reg <= '0;
        v_reg   <= 1'b0;
      end else begin
        v_reg <= comb_v[gi];
        if (comb_v[gi]) begin
          y_reg   <= comb_x[gi] - dly_reg;
          dly_reg <= comb_x[gi];
        end
      end
    end
    assign comb_x[gi+1] = y_reg;
    assign comb_v[gi+1] = v_reg;
  end

  // Only +full-scale can overflow after the shift; -full-scale is representable.
  assign shifted  = comb_x[ORDER] >>> S;
  assign out_next = (shifted == POS_FS) ? OUT_MAX : shifted[OUT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= comb_v[ORDER];
      if (comb_v[ORDER]) begin
        out_data <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_cic_dsm_decimator.sv
// Bench for cic_dsm_decimator: table of DC patterns, random streams against a
// convolution model of the CIC impulse response, and reset/latency corner cases.
module tb_cic_dsm_decimator;
  localparam int ORDER      = 3;
  localparam int DECIM_LOG2 = 6;
  localparam int OUT_WIDTH  = 16;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int S          = ORDER * DECIM_LOG2 + 1 - OUT_WIDTH;
  localparam int HLEN       = ORDER * (R - 1) + ORDER;

  logic clk = 1'b0;
  logic rst;
  logic in_en;
  logic dsm_in;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic out_valid;

  always #5 clk = ~clk;

  cic_dsm_decimator #(
    .ORDER(ORDER), .DECIM_LOG2(DECIM_LOG2), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .dsm_in(dsm_in),
    .out_data(out_data), .out_valid(out_valid)
  );

  typedef struct {
    logic [3:0] pat;
    int         plen;
    int         div;
    int         exp_val;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int h [HLEN];
  int hist [$];
  int en_cyc [$];
  int cyc = 0;
  int out_count = 0;
  int last_out = 0;
  int last_valid_cyc = 0;
  int exp_const = 0;
  bit use_model = 0;
  int period = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, output %0d)", name, act, exp, cyc, out_count);
    end
  endtask

  // Output n (1-based) = impulse response convolved with the zero-extended bit history.
  function automatic int model_out(input int n);
    int y = 0;
    int last = n * R - 1;
    for (int j = 0; j < HLEN; j++) begin
      if (last - j >= 0) y += h[j] * hist[last - j];
    end
    y = y >>> S;
    if (y == (1 << (OUT_WIDTH - 1))) y = y - 1;
    return y;
  endfunction

  task automatic tick(input logic en, input logic b);
    in_en  = en;
    dsm_in = b;
    @(posedge clk);
    cyc++;
    if (en) begin
      hist.push_back(b ? 1 : -1);
      en_cyc.push_back(cyc);
    end
    #1;
    if (out_valid) begin
      out_count++;
      if (out_count * R > en_cyc.size()) begin
        check("valid_before_block_complete", en_cyc.size(), out_count * R);
      end else begin
        check("latency", cyc - en_cyc[out_count * R - 1], ORDER + 1);
        if (out_count >= ORDER)
          check(use_model ? "model_value" : "table_value", int'(out_data),
                use_model ? model_out(out_count) : exp_const);
      end
      if (period > 0 && out_count >= 2) check("period", cyc - last_valid_cyc, period);
      last_valid_cyc = cyc;
      last_out = int'(out_data);
    end else begin
      check("hold", int'(out_data), last_out);
    end
  endtask

  task automatic clear_book();
    hist.delete();
    en_cyc.delete();
    out_count = 0;
    last_out  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_en = 1'b0;
    dsm_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_book();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
  endtask

  vec_t vecs [6];

  initial begin
    int tmp [HLEN];
    rst = 1'b1;
    in_en = 1'b0;
    dsm_in = 1'b0;

    // Impulse response: ORDER boxcars of length R, delayed by the integrator pipeline.
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[ORDER-1] = 1;
    for (int o = 0; o < ORDER; o++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) tmp[i] += h[i-k];
      end
      h = tmp;
    end

    vecs[0] = '{pat: 4'b0001, plen: 1, div: 1,   exp_val: 32767};
    vecs[1] = '{pat: 4'b0000, plen: 1, div: 1,   exp_val: -32768};
    vecs[2] = '{pat: 4'b0001, plen: 2, div: 1,   exp_val: 0};
    vecs[3] = '{pat: 4'b0111, plen: 4, div: 1,   exp_val: 16384};
    vecs[4] = '{pat: 4'b0001, plen: 4, div: 1,   exp_val: -16384};
    vecs[5] = '{pat: 4'b0001, plen: 1, div: 100, exp_val: 32767};

    for (int v = 0; v < 6; v++) begin
      int nout;
      int k;
      int budget;
      do_reset();
      use_model = 0;
      exp_const = vecs[v].exp_val;
      period = R * vecs[v].div;
      nout = (vecs[v].div > 1) ? 4 : 5;
      budget = (nout * R + ORDER + 2) * vecs[v].div;
      k = 0;
      for (int c = 0; c < budget && out_count < nout; c++) begin
        logic en;
        logic b;
        en = ((c % vecs[v].div) == vecs[v].div - 1);
        b = en ? vecs[v].pat[k % vecs[v].plen] : 1'($urandom_range(0, 1));
        tick(en, b);
        if (en) k++;
      end
      check("table_output_count", out_count, nout);
    end

    // Random streams: full rate, then randomly gated.
    for (int run = 0; run < 2; run++) begin
      int dens;
      do_reset();
      use_model = 1;
      dens = (run == 0) ? 80 : 30;
      period = (run == 0) ? R : 0;
      for (int c = 0; c < 40 * R && out_count < 12; c++) begin
        logic en;
        logic b;
        en = (run == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        b = 1'($urandom_range(0, 99) < dens);
        tick(en, b);
      end
      check("random_output_count", out_count, 12);
    end

    // Reset two clocks after the 4th decimation event: that token must vanish.
    do_reset();
    use_model = 0;
    exp_const = 32767;
    period = R;
    for (int c = 0; c < 5 * R && hist.size() < 4 * R; c++) tick(1'b1, 1'b1);
    check("pre_reset_outputs", out_count, 3);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_book();
    check("post_rst_data", int'(out_data), 0);
    for (int c = 0; c < 4 * R && out_count < 3; c++) tick(1'b1, 1'b1);
    check("post_rst_output_count", out_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cic_dsm_decimator.md
# cic_dsm_decimator

Reconstructs multi-bit PCM samples from the 1-bit bitstream produced by the first- and second-order DSM DACs. It is the receive end of the DSM link and fills the CIC filter slot in the DAC benches. The block is a Hogenauer CIC decimator with ORDER integrator stages at the bitstream rate, followed by decimation by 2^DECIM_LOG2. ORDER pipelined comb stages then run at the output rate, and a final scale/saturate stage produces a signed OUT_WIDTH sample with a one-cycle valid strobe.

## Interface
- ORDER, 3: number of integrator stages and number of comb stages; legal range 1..4.
- DECIM_LOG2, 6: decimation ratio R = 2^DECIM_LOG2; legal range 1..10.
- OUT_WIDTH, 16: width of the signed output sample. Elaboration must fail unless ORDER*DECIM_LOG2+1 >= OUT_WIDTH.
- clk  input  1  single clock for the whole block.
- rst  input  1  asynchronous, active-high reset.
- in_en  input  1  bitstream sample enable; dsm_in is consumed only on cycles where in_en=1. It is tied to 1 for full-rate DSM, or driven from clk_div.
- dsm_in  input  1  DSM bit; 1 maps to +1 and 0 maps to -1.
- out_data  output  OUT_WIDTH  signed reconstructed sample.
- out_valid  output  1  one-cycle pulse; out_data holds a new sample on this cycle.

## Operation
- Internal width: ACC_W = ORDER*DECIM_LOG2 + 2 bits, two's complement. All integrator, comb and delay registers are ACC_W wide.
- Integrators: on each in_en=1 cycle, integrator 1 adds +1 or -1, and integrator k adds the registered value of integrator k-1. Wrap-around is modular and intentional. Integrators must never saturate; the combs recover the exact result.
- Decimation counter: DECIM_LOG2 bits, incremented on each in_en=1 cycle and wrapping from R-1 to 0.
- Decimation event: an in_en=1 cycle with counter=R-1. On that cycle the updated last-integrator value is captured into the comb input register, and a valid token enters the comb pipeline.
- Combs: stage k computes y = x - x_delayed and then sets x_delayed <= x. It updates only when its valid token is present, giving one register stage per comb.
- Comb result range: [-R^ORDER, +R^ORDER] for an all-0 or all-1 block.
- Scale: full is arithmetic-shifted right by S = ORDER*DECIM_LOG2+1-OUT_WIDTH, which is 3 at the defaults.
- Saturate: if the shifted value equals +2^(OUT_WIDTH-1), out_data is 2^(OUT_WIDTH-1)-1. The negative full-scale value needs no clipping.
- out_data is registered and holds its value between out_valid pulses.
- Settling: the 1st through (ORDER-1)th outputs after reset are transient. From the ORDER-th output onward, the output equals the exact block-sum response. out_valid still pulses for the transient outputs.
- in_en=0: integrators and counter hold. The comb pipeline still drains any in-flight token.
- Reset (asynchronous, at any time including mid-block or mid-pipeline): the following all clear to 0 and in-flight tokens are discarded.
  - integrators, counter, comb registers and delay registers;
  - out_data = 0 and out_valid = 0.
- After reset deasserts, the first decimation event occurs on the R-th in_en=1 cycle.

## Timing
- in_en=1 at clock edge t updates the integrators at t. Integrator k sees input bit b at the edge that is k-1 edges later, i.e. the integrator chain is itself pipelined.
- Decimation-to-output latency: out_valid is asserted ORDER+1 clk after the decimation-event edge. At the defaults this is 4 clk.
- Output period equals R in_en pulses. With in_en tied high the period is R clk (64 at the defaults).
- Back-to-back decimation events (R=2 with in_en=1) must be supported. The comb pipeline must accept a token every clk with no stall.
- rst asserted: outputs take their reset values within the same cycle, without waiting for a clock edge.

## Test plan
All scenarios use the default parameters and hold rst=1 for 1 clk, then release it.
- All-ones at full rate: in_en=1, dsm_in=1 → out_valid every 64 clk; 3rd and later outputs equal 32767 (saturated); first out_valid is 4 clk after the 64th in_en.
- All-zeros at full rate → 3rd and later outputs equal -32768.
- Alternating bits starting 1,0,1,0,... → 3rd and later outputs equal 0.
- Repeating 1,1,1,0 → 3rd and later outputs equal 16384. Repeating 1,0,0,0 → -16384.
- Gated input: in_en from clk_div with DIV=100 and dsm_in=1 → out_valid spacing 6400 clk; 3rd and later outputs equal 32767; no state change on in_en=0 cycles.
- Reset mid-pipeline: assert rst 2 clk after a decimation event → out_valid never pulses for that block; out_data=0. After release with all-ones input, the first out_valid again arrives 4 clk after the 64th in_en.
